// File: rtl/buffer_access_arbiter.sv
// buffer_access_arbiter
// Round-robin arbiter sharing one circular buffer among NUM_REQ requesters.
// One buffer transaction is in flight at a time. The sequence is
// IDLE -> ISSUE -> SETTLE (2 cycles) -> DONE.
// Optional feature macro: BUF_ARB_TIMEOUT_EN. When it is defined, the arbiter
// adds a timeout output and gives up on ISSUE after WAIT_LIMIT cycles.
module buffer_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            rd_take,
    output logic [DATA_WIDTH-1:0]         buf_wdata,
    input  logic [DATA_WIDTH-1:0]         buf_rdata,
    input  logic                          buf_full,
    input  logic                          buf_empty,
    input  logic                          buf_ready,
    input  logic                          buf_valid,
    output logic                          write_enable,
    output logic                          read_enable,
`ifdef BUF_ARB_TIMEOUT_EN
    output logic                          timeout,
`endif
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     grant_idx_q, grant_idx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 write_enable_q, write_enable_d;
    logic                 read_enable_q, read_enable_d;
    logic [1:0]           cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W:0]       scan_sum;
    logic                 handshake;

`ifdef BUF_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(WAIT_LIMIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // Read data flows straight from the buffer to the requesters; the arbiter only supplies the rd_take strobe
    logic unused_inputs;
    assign unused_inputs = (^buf_rdata) ^ (WAIT_LIMIT == 0);

    // Find the first eligible requester scanning from rr_ptr upward, wrapping modulo NUM_REQ
    always_comb begin
        eligible   = req & ((req_wr & ~{NUM_REQ{buf_full}}) | (~req_wr & ~{NUM_REQ{buf_empty}}));
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!pick_valid && eligible[scan_sum[PTR_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    // Next-state logic: grant in IDLE, wait for the handshake in ISSUE, count out SETTLE, pulse done
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_idx_d    = grant_idx_q;
        rr_ptr_d       = rr_ptr_q;
        write_enable_d = write_enable_q;
        read_enable_d  = read_enable_q;
        cnt_d          = cnt_q;
        handshake      = (write_enable_q & buf_ready) | (read_enable_q & buf_valid);
`ifdef BUF_ARB_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    grant_idx_d       = pick_idx;
                    rr_ptr_d          = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                    write_enable_d    = req_wr[pick_idx];
                    read_enable_d     = ~req_wr[pick_idx];
                    state_d           = ISSUE;
`ifdef BUF_ARB_TIMEOUT_EN
                    wait_cnt_d        = '0;
`endif
                end
            end
            ISSUE: begin
                if (handshake) begin
                    write_enable_d = 1'b0;
                    read_enable_d  = 1'b0;
                    cnt_d          = 2'd2;
                    state_d        = SETTLE;
                end
`ifdef BUF_ARB_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    write_enable_d = 1'b0;
                    read_enable_d  = 1'b0;
                    timeout_d      = 1'b1;
                    state_d        = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (cnt_q == 2'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
`ifdef BUF_ARB_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_idx_q    <= '0;
            rr_ptr_q       <= '0;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            cnt_q          <= '0;
`ifdef BUF_ARB_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_idx_q    <= grant_idx_d;
            rr_ptr_q       <= rr_ptr_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            cnt_q          <= cnt_d;
`ifdef BUF_ARB_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign write_enable = write_enable_q;
    assign read_enable  = read_enable_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE) ? grant_q : '0;
    assign rd_take      = (state_q == ISSUE && read_enable_q && buf_valid) ? grant_q : '0;
    assign buf_wdata    = (state_q == ISSUE || state_q == SETTLE)
                          ? req_wdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef BUF_ARB_TIMEOUT_EN
    assign timeout      = (state_q == DONE) & timeout_q;
`endif

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// tb_buffer_access_arbiter
// Directed bench for buffer_access_arbiter (NUM_REQ=4, DATA_WIDTH=16).
// Optional feature macro: BUF_ARB_TIMEOUT_EN. When it is defined, the bench
// also exercises the ISSUE timeout.
module tb_buffer_access_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_wr;
    logic [63:0] req_wdata;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  rd_take;
    logic [15:0] buf_wdata;
    logic [15:0] buf_rdata;
    logic        buf_full;
    logic        buf_empty;
    logic        buf_ready;
    logic        buf_valid;
    logic        write_enable;
    logic        read_enable;
    logic        busy;
`ifdef BUF_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int checks;
    int errors;
    logic [15:0] slice_data [4];

    buffer_access_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(16),
        .WAIT_LIMIT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_wr(req_wr),
        .req_wdata(req_wdata),
        .grant(grant),
        .done(done),
        .rd_take(rd_take),
        .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata),
        .buf_full(buf_full),
        .buf_empty(buf_empty),
        .buf_ready(buf_ready),
        .buf_valid(buf_valid),
        .write_enable(write_enable),
        .read_enable(read_enable),
`ifdef BUF_ARB_TIMEOUT_EN
        .timeout(timeout),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] wr,
                                 input logic full, input logic empty);
        req       = r;
        req_wr    = wr;
        buf_full  = full;
        buf_empty = empty;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req       = '0;
        req_wr    = '0;
        req_wdata = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
        buf_rdata = '0;
        buf_full  = 1'b0;
        buf_empty = 1'b1;
        buf_ready = 1'b0;
        buf_valid = 1'b0;
        slice_data[0] = 16'hA5A5;
        slice_data[1] = 16'h2222;
        slice_data[2] = 16'h3333;
        slice_data[3] = 16'h4444;

        // Reset state
        #3;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_we", 32'(write_enable), 32'h0);
        checkOutput("rst_re", 32'(read_enable), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_wdata", 32'(buf_wdata), 32'h0);
        tick();
        rst = 1'b1;
        #1;

        // 1: single write
        $display("[TB] write from requester 0");
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1);
        tick();
        checkOutput("w_grant", 32'(grant), 32'h1);
        checkOutput("w_we", 32'(write_enable), 32'h1);
        checkOutput("w_re", 32'(read_enable), 32'h0);
        checkOutput("w_busy", 32'(busy), 32'h1);
        checkOutput("w_wdata_issue", 32'(buf_wdata), 32'hA5A5);
        buf_ready = 1'b1;
        #1;
        checkOutput("w_rdtake", 32'(rd_take), 32'h0);
        tick();
        buf_ready = 1'b0;
        #1;
        checkOutput("w_we_drop", 32'(write_enable), 32'h0);
        checkOutput("w_wdata_s1", 32'(buf_wdata), 32'hA5A5);
        checkOutput("w_done_s1", 32'(done), 32'h0);
        tick();
        checkOutput("w_wdata_s2", 32'(buf_wdata), 32'hA5A5);
        checkOutput("w_done_s2", 32'(done), 32'h0);
        tick();
        checkOutput("w_done", 32'(done), 32'h1);
        checkOutput("w_wdata_done", 32'(buf_wdata), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("w_idle_grant", 32'(grant), 32'h0);
        checkOutput("w_idle_done", 32'(done), 32'h0);
        checkOutput("w_idle_busy", 32'(busy), 32'h0);

        // 2: single read with a one-cycle wait for valid
        $display("[TB] read from requester 1");
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("r_grant", 32'(grant), 32'h2);
        checkOutput("r_re", 32'(read_enable), 32'h1);
        checkOutput("r_we", 32'(write_enable), 32'h0);
        checkOutput("r_rdtake_wait", 32'(rd_take), 32'h0);
        tick();
        checkOutput("r_re_held", 32'(read_enable), 32'h1);
        buf_valid = 1'b1;
        buf_rdata = 16'h1234;
        #1;
        checkOutput("r_rdtake", 32'(rd_take), 32'h2);
        tick();
        checkOutput("r_re_drop", 32'(read_enable), 32'h0);
        checkOutput("r_rdtake_once", 32'(rd_take), 32'h0);
        buf_valid = 1'b0;
        tick();
        checkOutput("r_done_s2", 32'(done), 32'h0);
        tick();
        checkOutput("r_done", 32'(done), 32'h2);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("r_idle_busy", 32'(busy), 32'h0);

        // 3: round robin over four writers
        $display("[TB] round robin");
        doReset();
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput("rr_grant", 32'(grant), 32'(4'b0001 << (n % 4)));
            checkOutput("rr_wdata", 32'(buf_wdata), 32'(slice_data[n % 4]));
            buf_ready = 1'b1;
            tick();
            buf_ready = 1'b0;
            tick();
            checkOutput("rr_done_early", 32'(done), 32'h0);
            tick();
            checkOutput("rr_done", 32'(done), 32'(4'b0001 << (n % 4)));
            tick();
            checkOutput("rr_done_width", 32'(done), 32'h0);
            checkOutput("rr_gap_grant", 32'(grant), 32'h0);
        end

        // 4: full buffer skips the writer, reader goes first
        $display("[TB] full/empty skip");
        doReset();
        applyStimulus(4'b0011, 4'b0001, 1'b1, 1'b0);
        tick();
        checkOutput("skip_grant_rd", 32'(grant), 32'h2);
        checkOutput("skip_re", 32'(read_enable), 32'h1);
        buf_valid = 1'b1;
        #1;
        checkOutput("skip_rdtake", 32'(rd_take), 32'h2);
        tick();
        buf_valid = 1'b0;
        tick();
        tick();
        checkOutput("skip_done_rd", 32'(done), 32'h2);
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
        tick();
        checkOutput("skip_full_idle", 32'(grant), 32'h0);
        tick();
        checkOutput("skip_full_hold", 32'(grant), 32'h0);
        checkOutput("skip_full_busy", 32'(busy), 32'h0);
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        tick();
        checkOutput("skip_grant_wr", 32'(grant), 32'h1);
        checkOutput("skip_we", 32'(write_enable), 32'h1);
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("skip_done_wr", 32'(done), 32'h1);
        tick();

        // 5: reset while a read is in ISSUE
        $display("[TB] reset mid-issue");
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("mr_re_before", 32'(read_enable), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mr_re", 32'(read_enable), 32'h0);
        checkOutput("mr_grant", 32'(grant), 32'h0);
        checkOutput("mr_busy", 32'(busy), 32'h0);
        #1;
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        checkOutput("mr_idle_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("mr_ptr_zero", 32'(grant), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);

`ifdef BUF_ARB_TIMEOUT_EN
        // 6: timeout when the buffer never answers
        $display("[TB] timeout");
        doReset();
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1);
        tick();
        checkOutput("to_we_start", 32'(write_enable), 32'h1);
        for (int i = 1; i < 15; i++) begin
            tick();
            checkOutput("to_we_held", 32'(write_enable), 32'h1);
        end
        tick();
        checkOutput("to_we_drop", 32'(write_enable), 32'h0);
        checkOutput("to_timeout", 32'(timeout), 32'h1);
        checkOutput("to_done", 32'(done), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("to_timeout_clr", 32'(timeout), 32'h0);
        checkOutput("to_idle", 32'(busy), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
